// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared types and constants for the quadrature encoder generator
package quad_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Phase encodings are {signalA, signalB}
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic dir);
    logic [1:0] nxt;
    nxt = ab;
    if (dir == DIR_CW) begin
      case (ab)
        PH_00:   nxt = PH_10;
        PH_10:   nxt = PH_11;
        PH_11:   nxt = PH_01;
        default: nxt = PH_00;
      endcase
    end else begin
      case (ab)
        PH_00:   nxt = PH_01;
        PH_01:   nxt = PH_11;
        PH_11:   nxt = PH_10;
        default: nxt = PH_00;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/quad_step_timer.sv
// rtl/quad_step_timer.sv - reloadable down-counter producing a one-cycle tick per period
module quad_step_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                load,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  // Expiry reloads from the same period input, so edges stay exactly period apart
  assign tick = en && !load && (cnt_q <= PERIOD_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = period;
    end else if (en) begin
      cnt_d = tick ? period : cnt_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/quadrature_encoder_gen.sv
// rtl/quadrature_encoder_gen.sv - emits a counted, paced quadrature A/B edge train
module quadrature_encoder_gen
  import quad_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int STEP_W   = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic                dir,
  input  logic [STEP_W-1:0]   steps,
  input  logic [PERIOD_W-1:0] period,
  input  logic                abort,
  output logic                signalA,
  output logic                signalB,
  output logic                busy,
  output logic                done,
  output logic [STEP_W-1:0]   position
);

  state_e              state_q, state_d;
  logic [1:0]          ab_q, ab_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic [STEP_W-1:0]   pos_q, pos_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tmr_load, tmr_en, tmr_tick;
  logic [PERIOD_W-1:0] period_eff, tmr_period;

  assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
  assign tmr_en     = (state_q == RUN) && !abort;
  assign tmr_period = tmr_load ? period_eff : period_q;

  quad_step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .load   (tmr_load),
    .en     (tmr_en),
    .period (tmr_period),
    .tick   (tmr_tick)
  );

  always_comb begin
    state_d  = state_q;
    ab_d     = ab_q;
    dir_d    = dir_q;
    rem_d    = rem_q;
    pos_d    = pos_q;
    period_d = period_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (steps != '0) begin
            state_d  = RUN;
            dir_d    = dir;
            rem_d    = steps;
            period_d = period_eff;
            busy_d   = 1'b1;
            tmr_load = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Abort wins over a coincident tick so no edge leaks out after it
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (tmr_tick) begin
          ab_d  = next_phase(ab_q, dir_q);
          pos_d = (dir_q == DIR_CW) ? pos_q + STEP_W'(1) : pos_q - STEP_W'(1);
          rem_d = rem_q - STEP_W'(1);
          if (rem_q == STEP_W'(1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      ab_q     <= PH_00;
      dir_q    <= DIR_CCW;
      rem_q    <= '0;
      pos_q    <= '0;
      period_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ab_q     <= ab_d;
      dir_q    <= dir_d;
      rem_q    <= rem_d;
      pos_q    <= pos_d;
      period_q <= period_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign signalA  = ab_q[1];
  assign signalB  = ab_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign position = pos_q;

endmodule

// File: tb/tb_quadrature_encoder_gen.sv
// tb/tb_quadrature_encoder_gen.sv - directed self-checking bench for quadrature_encoder_gen
module tb_quadrature_encoder_gen;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [15:0] steps = '0;
  logic [15:0] period = '0;
  logic        abort = 1'b0;
  logic        signalA, signalB, busy, done;
  logic [15:0] position;

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc = 0;
  int         start_cyc = 0;
  logic [1:0] prev_ab = 2'b00;
  logic [1:0] edge_ab[$];
  int         edge_cyc[$];
  int         rights = 0;
  int         lefts = 0;
  int         done_cnt = 0;
  int         done_cyc = -1;

  quadrature_encoder_gen #(.PERIOD_W(16), .STEP_W(16)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .dir      (dir),
    .steps    (steps),
    .period   (period),
    .abort    (abort),
    .signalA  (signalA),
    .signalB  (signalB),
    .busy     (busy),
    .done     (done),
    .position (position)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Edge logger plus direction_of_rotation-style decoder: right when prevB ^ newA
  always @(negedge CLK) begin
    if ({signalA, signalB} != prev_ab) begin
      edge_ab.push_back({signalA, signalB});
      edge_cyc.push_back(cyc);
      if (prev_ab[0] ^ signalA) rights = rights + 1;
      else                      lefts  = lefts + 1;
      prev_ab = {signalA, signalB};
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    edge_ab.delete();
    edge_cyc.delete();
    rights   = 0;
    lefts    = 0;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge CLK);
    RST_N = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge CLK);
    check({tag, "_ab"},   {30'd0, signalA, signalB}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pos"},  {16'd0, position}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    clear_log();
  endtask

  task automatic do_start(input logic d, input logic [15:0] s, input logic [15:0] p);
    @(negedge CLK);
    start  = 1'b1;
    dir    = d;
    steps  = s;
    period = p;
    @(negedge CLK);
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_edges(input string tag, input int cnt, input int max);
    int n;
    n = 0;
    while (edge_ab.size() < cnt && n < max) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_edge_timeout"}, edge_ab.size(), cnt);
  endtask

  task automatic check_edges(input string tag, input logic [1:0] exp_ab[], input int gap);
    int prev;
    prev = start_cyc;
    check({tag, "_n_edges"}, edge_ab.size(), exp_ab.size());
    for (int i = 0; i < exp_ab.size() && i < edge_ab.size(); i++) begin
      check($sformatf("%s_ab%0d", tag, i), {30'd0, edge_ab[i]}, {30'd0, exp_ab[i]});
      check($sformatf("%s_gap%0d", tag, i), edge_cyc[i] - prev, gap);
      prev = edge_cyc[i];
    end
  endtask

  initial begin
    logic [1:0] cw8[]  = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] ccw5[] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    logic [1:0] ab4[]  = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] p0[]   = '{2'b00, 2'b10, 2'b11};

    apply_reset("rst");

    // CW, 8 steps, period 4
    do_start(1'b1, 16'd8, 16'd4);
    check("cw_busy", {31'd0, busy}, 32'd1);
    wait_idle("cw", 200);
    check_edges("cw", cw8, 4);
    check("cw_pos", {16'd0, position}, 32'd8);
    check("cw_done_cnt", done_cnt, 1);
    check("cw_done_at_last", done_cyc, edge_cyc.size() > 0 ? edge_cyc[edge_cyc.size()-1] : -2);
    check("cw_right", rights, 8);
    check("cw_left", lefts, 0);

    // CCW, 5 steps, period 2, from reset phase 00
    apply_reset("rst2");
    do_start(1'b0, 16'd5, 16'd2);
    wait_idle("ccw", 200);
    check_edges("ccw", ccw5, 2);
    check("ccw_pos", {16'd0, position}, 32'h0000FFFB);
    check("ccw_done_cnt", done_cnt, 1);
    check("ccw_left", lefts, 5);
    check("ccw_right", rights, 0);

    // Abort after 4 edges with a start in the same cycle; phase continues from 01
    clear_log();
    do_start(1'b1, 16'd10, 16'd3);
    wait_edges("abort", 4, 100);
    start = 1'b1;
    abort = 1'b1;
    steps = 16'd2;
    period = 16'd1;
    @(negedge CLK);
    start = 1'b0;
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (12) @(negedge CLK);
    check_edges("abort", ab4, 3);
    check("abort_hold", {30'd0, signalA, signalB}, 32'd1);
    check("abort_done", done_cnt, 0);
    check("abort_pos", {16'd0, position}, 32'h0000FFFF);
    check("abort_busy_late", {31'd0, busy}, 32'd0);

    // Abort in IDLE drops a coincident start
    clear_log();
    @(negedge CLK);
    start = 1'b1;
    abort = 1'b1;
    steps = 16'd5;
    period = 16'd2;
    @(negedge CLK);
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge CLK);
    check("idle_abort_edges", edge_ab.size(), 0);
    check("idle_abort_done", done_cnt, 0);

    // Zero steps: done one cycle later, nothing else
    clear_log();
    do_start(1'b1, 16'd0, 16'd5);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    @(negedge CLK);
    check("zero_done_pulse", {31'd0, done}, 32'd0);
    repeat (6) @(negedge CLK);
    check("zero_edges", edge_ab.size(), 0);
    check("zero_done_cnt", done_cnt, 1);

    // Zero period behaves as 1: an edge every cycle, position wraps through 0
    clear_log();
    do_start(1'b1, 16'd3, 16'd0);
    wait_idle("p0", 50);
    check_edges("p0", p0, 1);
    check("p0_pos", {16'd0, position}, 32'h00000002);
    check("p0_done_cnt", done_cnt, 1);

    // Asynchronous reset mid-move
    clear_log();
    do_start(1'b0, 16'd20, 16'd5);
    wait_edges("mid", 1, 50);
    check("mid_pre_ab", {30'd0, signalA, signalB}, 32'd2);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_ab",   {30'd0, signalA, signalB}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_pos",  {16'd0, position}, 32'd0);
    repeat (2) @(negedge CLK);
    clear_log();
    check("mid_no_done", {31'd0, done}, 32'd0);

    // Start accepted on the first rising edge after reset release
    start  = 1'b1;
    dir    = 1'b1;
    steps  = 16'd1;
    period = 16'd1;
    RST_N  = 1'b1;
    @(negedge CLK);
    start     = 1'b0;
    start_cyc = cyc;
    check("post_rst_busy", {31'd0, busy}, 32'd1);
    wait_idle("post", 20);
    check("post_edges", edge_ab.size(), 1);
    check("post_ab", {30'd0, signalA, signalB}, 32'd2);
    check("post_pos", {16'd0, position}, 32'd1);
    check("post_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/quadrature_encoder_gen.md
QUADRATURE_ENCODER_GEN -- requirements
Module: quadrature_encoder_gen

Interface
REQ-001 Parameter PERIOD_W, default 16: width of the quarter-step period input, in CLK cycles.
REQ-002 Parameter STEP_W, default 16: width of the step-count input and the position output.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 CLK  in  1  system clock; all logic is rising-edge.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 start  in  1  single-cycle move request.
REQ-007 dir  in  1  1 = clockwise (right), 0 = counter-clockwise (left); sampled with start.
REQ-008 steps  in  STEP_W  number of quadrature edges to emit; sampled with start.
REQ-009 period  in  PERIOD_W  CLK cycles between successive edges; sampled with start.
REQ-010 abort  in  1  stop the current move.
REQ-011 signalA  out  1  quadrature channel A, registered.
REQ-012 signalB  out  1  quadrature channel B, registered.
REQ-013 busy  out  1  high while a move is in progress.
REQ-014 done  out  1  one-cycle pulse when a move completes normally.
REQ-015 position  out  STEP_W  signed edge count: +1 per CW edge, -1 per CCW edge.

Function
REQ-016 Two states: IDLE and RUN.
REQ-017 IDLE to RUN: start=1, abort=0 and steps!=0.
- The module latches dir, steps and period.
- busy rises on the next cycle.
REQ-018 start with steps=0 in IDLE: state stays IDLE; done pulses on the next cycle; signalA/signalB unchanged.
REQ-019 A latched period of 0 is treated as 1.
REQ-020 Edge timing in RUN:
- An internal timer counts the latched period.
- The first edge appears on the outputs period cycles after the start cycle.
- Each later edge follows the previous one by exactly period cycles.
REQ-021 Clockwise (A,B) sequence: 00 -> 10 -> 11 -> 01 -> 00. signalA rises while signalB=0.
REQ-022 Counter-clockwise (A,B) sequence: 00 -> 01 -> 11 -> 10 -> 00. signalA rises while signalB=1.
REQ-023 Each edge changes exactly one of signalA/signalB; the phase wraps modulo 4.
REQ-024 Each edge decrements the remaining count and adjusts position by ±1 in the same cycle.
REQ-025 position wraps modulo 2^STEP_W with no saturation.
REQ-026 On the cycle the last edge is emitted:
- done=1 for one cycle;
- busy drops in the same cycle;
- state returns to IDLE.
REQ-027 start while in RUN is ignored; the latched parameters do not change.
REQ-028 abort in RUN:
- state returns to IDLE on the next edge of CLK;
- no further edges are emitted;
- signalA/signalB hold their current levels;
- done is not pulsed.
REQ-029 abort in IDLE takes priority over a simultaneous start; the start is dropped.
REQ-030 A new move starts from the current phase, not from 00. Edges stay continuous across moves.

Reset
REQ-031 RST_N=0 immediately (asynchronously) forces the following values, independent of CLK:
- state=IDLE;
- signalA=0, signalB=0;
- busy=0, done=0, position=0;
- timer and remaining count = 0.
REQ-032 Reset asserted mid-move drops the move with no done pulse.
REQ-033 After RST_N deasserts, the block accepts start on the first rising edge.

Structure
REQ-034 Shared package quad_pkg holds:
- the state enum (IDLE, RUN);
- the 2-bit phase encodings;
- the DIR_CW=1 and DIR_CCW=0 constants.
REQ-035 The module has one sub-module, quad_step_timer.
- It is a PERIOD_W-bit reloadable down-counter.
- It outputs a one-cycle tick on expiry.
- It has load and enable inputs.
REQ-036 The phase, position and count logic stays in quadrature_encoder_gen.

Verification
REQ-037 CW move. Stimulus: start, dir=1, steps=8, period=4. Required response:
- (A,B) sequence 10,11,01,00,10,11,01,00;
- edges every 4 cycles;
- position=8;
- one done pulse.
REQ-038 CCW move. Stimulus: start, dir=0, steps=5, period=2, from phase 00. Required response:
- (A,B) sequence 01,11,10,00,01;
- position=-5 (0xFFFB).
REQ-039 Abort and ignored start. Stimulus: start, steps=10, period=3; abort after 4 edges; then start again during the abort cycle. Required response:
- 4 edges only;
- no done pulse;
- outputs hold;
- busy=0 one cycle later.
REQ-040 Zero steps and zero period. Stimulus: steps=0. Required response: done pulse one cycle later, no edges, busy stays 0. Stimulus: period=0, steps=3. Required response: an edge every cycle.
REQ-041 Reset mid-move. Stimulus: RST_N low between clocks during RUN. Required response:
- outputs go to 0 immediately;
- position=0;
- no done pulse.
REQ-042 Loopback check: the bench feeds signalA/signalB into the team's direction_of_rotation-style decoder. Required response: the decoder indicates right for CW moves and left for CCW moves.
